// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter: FSM encoding,
// parity modes and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Parity bit the line should carry, given the XOR of the payload bits.
    function automatic logic exp_parity(input logic payload_xor, input int mode);
        return (mode == PAR_ODD) ? ~payload_xor : payload_xor;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; tick marks the terminal count of either
// a half period (after load_half) or a full period (auto-reload, load_full).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic load_half,
    input  logic load_full,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] HALF_M1 = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W-1:0] FULL_M1 = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= HALF_M1;
        end else if (load_half) begin
            cnt <= HALF_M1;
        end else if (load_full || cnt == '0) begin
            cnt <= FULL_M1;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, recovers 8N1/8E1/8O1 frames and hands each
// byte out over valid/ready, flagging framing, parity and overrun errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output state_t               fsm_state
);

    // Handshake: a byte transfers on a rising clk edge where valid && ready;
    // data holds steady while valid is high, valid never drops without ready.

    state_t state, next_state;

    logic rx_meta, rx_s, rx_prev;
    logic tick;
    logic [3:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic perr;

    logic load_half, sample_data, sample_par, last_bit;
    logic stop_good, stop_perr, stop_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_half (load_half),
        .load_full (1'b0),
        .tick      (tick)
    );

    assign last_bit = (bit_cnt == 4'(DATA_BITS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (rx_prev && !rx_s) next_state = ST_START;
            ST_START:  if (tick) next_state = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (tick && last_bit)
                           next_state = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY: if (tick) next_state = ST_STOP;
            ST_STOP:   if (tick) next_state = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_s) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Timer sits preloaded with a half period while idle, so the start-bit
    // check lands mid-bit and later samples auto-reload a full period.
    always_comb begin
        load_half   = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        sample_data = (state == ST_DATA) && tick;
        sample_par  = (state == ST_PARITY) && tick;
        stop_good   = (state == ST_STOP) && tick && rx_s && !perr;
        stop_perr   = (state == ST_STOP) && tick && rx_s && perr;
        stop_bad    = (state == ST_STOP) && tick && !rx_s;
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            perr        <= 1'b0;
            data        <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_bad;
            parity_err  <= stop_perr;
            overrun_err <= stop_good && valid && !ready;

            if (state == ST_START) begin
                bit_cnt <= '0;
                perr    <= 1'b0;
            end else if (sample_data) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (sample_data) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end

            if (sample_par) begin
                perr <= (rx_s != exp_parity(^shreg, PARITY));
            end

            // A byte arriving while the previous one is unaccepted is dropped.
            if (stop_good && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8: an 8N1 instance and an 8E1
// instance driven by a bit-level TX model, checked against expected bytes.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx = 1'b1;
    logic rx_e = 1'b1;
    logic ready = 1'b1;

    logic [7:0] data, data_e;
    logic valid, busy, frame_err, parity_err, overrun_err;
    logic valid_e, busy_e, frame_err_e, parity_err_e, overrun_err_e;
    state_t fsm_state, fsm_state_e;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .busy(busy), .frame_err(frame_err), .parity_err(parity_err),
        .overrun_err(overrun_err), .fsm_state(fsm_state)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN)) dut_e (
        .clk(clk), .rst(rst), .rx(rx_e), .data(data_e), .valid(valid_e), .ready(ready),
        .busy(busy_e), .frame_err(frame_err_e), .parity_err(parity_err_e),
        .overrun_err(overrun_err_e), .fsm_state(fsm_state_e)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [7:0] got_q[$], got_e_q[$];
    logic [7:0] exp_q[$], exp_e_q[$];
    int valid_cyc, valid_cyc_e, fe_cnt, pe_cnt, ov_cnt, fe_cnt_e, pe_cnt_e, ov_cnt_e;
    int valid_at;
    bit valid_seen, busy_seen;

    always @(negedge clk) begin
        if (valid) valid_cyc++;
        if (valid_e) valid_cyc_e++;
        if (valid && !valid_seen) begin
            valid_seen = 1'b1;
            valid_at   = cyc;
        end
        if (busy) busy_seen = 1'b1;
        if (valid && ready) got_q.push_back(data);
        if (valid_e && ready) got_e_q.push_back(data_e);
        fe_cnt   += int'(frame_err);
        pe_cnt   += int'(parity_err);
        ov_cnt   += int'(overrun_err);
        fe_cnt_e += int'(frame_err_e);
        pe_cnt_e += int'(parity_err_e);
        ov_cnt_e += int'(overrun_err_e);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input bit sel);
        int n_got, n_exp;
        logic [7:0] g, e;
        n_got = sel ? got_e_q.size() : got_q.size();
        n_exp = sel ? exp_e_q.size() : exp_q.size();
        check({tag, "_count"}, 32'(n_got), 32'(n_exp));
        for (int i = 0; i < n_exp && i < n_got; i++) begin
            g = sel ? got_e_q[i] : got_q[i];
            e = sel ? exp_e_q[i] : exp_q[i];
            check({tag, "_byte"}, 32'(g), 32'(e));
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_e_q.delete();
        exp_q.delete();
        exp_e_q.delete();
        valid_cyc = 0; valid_cyc_e = 0;
        fe_cnt = 0; pe_cnt = 0; ov_cnt = 0;
        fe_cnt_e = 0; pe_cnt_e = 0; ov_cnt_e = 0;
        valid_seen = 1'b0;
        busy_seen = 1'b0;
        valid_at = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input bit sel);
        if (sel) rx_e = v;
        else     rx = v;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit sel, input bit with_par,
                              input bit bad_par, input logic stop_v);
        drive_bit(1'b0, sel);
        for (int i = 0; i < 8; i++) drive_bit(b[i], sel);
        if (with_par) drive_bit((^b) ^ bad_par, sel);
        drive_bit(stop_v, sel);
    endtask

    // ---------------- stimulus ----------------
    int start_cyc;

    initial begin
        clear_mon();
        rst = 1'b0;
        wait_cycles(3);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_errs", 32'({frame_err, parity_err, overrun_err}), 32'h0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        rst = 1'b1;
        wait_cycles(4);

        // 8N1 frame 0xA5 with ready high; valid 79 cycles after the line falls
        clear_mon();
        ready = 1'b1;
        exp_q.push_back(8'hA5);
        start_cyc = cyc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_cycles(16);
        check_bytes("a5", 1'b0);
        check("a5_valid_cycles", 32'(valid_cyc), 32'd1);
        check("a5_latency", 32'(valid_at - start_cyc), 32'd79);
        check("a5_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd0);

        // short low glitch on idle line
        clear_mon();
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        for (int i = 0; i < 5 && busy; i++) @(negedge clk);
        check("glitch_busy_fall", 32'(busy), 32'h0);
        wait_cycles(32);
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_valid", 32'(valid_cyc), 32'd0);
        check("glitch_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd0);

        // 8E1 frame 0x3C with wrong parity, then with correct parity
        clear_mon();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_cycles(16);
        check("par_bad_pe", 32'(pe_cnt_e), 32'd1);
        check("par_bad_valid", 32'(valid_cyc_e), 32'd0);
        check("par_bad_fe", 32'(fe_cnt_e), 32'd0);
        exp_e_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_cycles(16);
        check_bytes("par_good", 1'b1);
        check("par_good_pe", 32'(pe_cnt_e), 32'd1);

        // stop bit low, line held low for 20 bits, then recovery with 0x11
        clear_mon();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_cycles(20 * CPB);
        check("brk_fe", 32'(fe_cnt), 32'd1);
        check("brk_valid", 32'(valid_cyc), 32'd0);
        check("brk_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        check("brk_idle", 32'(busy), 32'h0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_cycles(16);
        check_bytes("brk_rx11", 1'b0);
        check("brk_fe_once", 32'(fe_cnt), 32'd1);

        // overrun: ready low, 0x01 and 0x02 back to back
        clear_mon();
        ready = 1'b0;
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_first_valid", 32'(valid), 32'h1);
        check("ovr_first_ov", 32'(ov_cnt), 32'd0);
        send_frame(8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_cycles(4);
        check("ovr_ov", 32'(ov_cnt), 32'd1);
        check("ovr_data_held", 32'(data), 32'h01);
        check("ovr_valid_held", 32'(valid), 32'h1);
        exp_q.push_back(8'h01);
        ready = 1'b1;
        wait_cycles(4);
        check("ovr_valid_drop", 32'(valid), 32'h0);
        check_bytes("ovr_bytes", 1'b0);

        // reset during data bit 4 of 0xFF, then 0x5A
        clear_mon();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        rx = 1'b1;
        wait_cycles(4);
        check("mid_busy_before", 32'(busy), 32'h1);
        rst = 1'b0;
        wait_cycles(2);
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
        rst = 1'b1;
        wait_cycles(3 * CPB);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_cycles(16);
        check_bytes("mid_rx5a", 1'b0);
        check("mid_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
